nastilite_cfg_loader: RTL

Boot-time configuration sequencer that programs the DDR controller's timing/configuration registers over NASTILite. On a start pulse it latches a table of `C_NUM_REGS` register words and writes them one transaction at a time, strictly non-overlapped, to consecutive word addresses of the NASTILite configuration slave. It then reports completion and error status to the system reset/init logic. It sits between the init sequencer and the configuration register frontend, and is the only NASTILite master of that slave during initialisation.

---
 rtl/nastilite_cfg_loader_if.sv | 33 +++
 rtl/nastilite_cfg_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nastilite_cfg_loader_if.sv
// NASTILite (AXI4-Lite style) channel bundle between the config loader and its slave.
interface nasti_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) ();
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/nastilite_cfg_loader.sv
// Boot-time loader: writes C_NUM_REGS latched words to consecutive slave word addresses, one
// transaction at a time. Define CFG_LOADER_VERIFY_EN to add a word-for-word readback pass.
module nastilite_cfg_loader #(
  parameter int C_NASTI_ADDR_WIDTH = 5,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                                       m_nastilite_clk,
  input  logic                                       m_nastilite_aresetn,
  input  logic                                       start,
  input  logic [C_NUM_REGS*C_NASTI_DATA_WIDTH-1:0]   init_data,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       error,
  output logic [3:0]                                 err_index,
  nasti_if.master                                    m_nastilite
);

  localparam int AW   = C_NASTI_ADDR_WIDTH;
  localparam int DW   = C_NASTI_DATA_WIDTH;
  localparam int NB   = DW / 8;
  localparam int ALSB = $clog2(NB);
  localparam int TW   = C_NUM_REGS * DW;
  localparam logic [3:0] LAST = 4'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    FIN     = 3'd5
  } state_t;

  function automatic logic [AW-1:0] word_addr(input logic [3:0] i);
    return AW'({28'd0, i} << ALSB);
  endfunction

  function automatic logic [DW-1:0] word_sel(input logic [TW-1:0] tbl, input logic [3:0] i);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (i == 4'(k)) w = tbl[k*DW +: DW];
    end
    return w;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic            aw_vld_q, aw_vld_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_vld_q, w_vld_d;
  logic [DW-1:0]   w_dat_q, w_dat_d;
  logic [NB-1:0]   w_strb_q, w_strb_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            b_rdy_q, b_rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [3:0]      err_idx_q, err_idx_d;

  logic            aw_hs, w_hs, b_hs;
  logic            issue_wr, finish, fail;
  logic [3:0]      nidx;

  assign aw_hs = aw_vld_q & m_nastilite.aw_ready;
  assign w_hs  = w_vld_q & m_nastilite.w_ready;
  assign b_hs  = b_rdy_q & m_nastilite.b_valid;

`ifdef CFG_LOADER_VERIFY_EN
  logic            ar_vld_q, ar_vld_d;
  logic [AW-1:0]   ar_addr_q, ar_addr_d;
  logic            r_rdy_q, r_rdy_d;
  logic            ar_hs, r_hs, issue_rd;

  assign ar_hs = ar_vld_q & m_nastilite.ar_ready;
  assign r_hs  = r_rdy_q & m_nastilite.r_valid;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tbl_d     = tbl_q;
    aw_vld_d  = aw_vld_q;
    aw_addr_d = aw_addr_q;
    w_vld_d   = w_vld_q;
    w_dat_d   = w_dat_q;
    w_strb_d  = w_strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    b_rdy_d   = b_rdy_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    issue_wr  = 1'b0;
    finish    = 1'b0;
    fail      = 1'b0;
    nidx      = idx_q + 4'd1;
`ifdef CFG_LOADER_VERIFY_EN
    ar_vld_d  = ar_vld_q;
    ar_addr_d = ar_addr_q;
    r_rdy_d   = r_rdy_q;
    issue_rd  = 1'b0;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          tbl_d     = init_data;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = 4'd0;
          busy_d    = 1'b1;
          nidx      = 4'd0;
          issue_wr  = 1'b1;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave only once both have landed
        if (aw_hs) begin
          aw_vld_d  = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          w_vld_d  = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d = WR_RESP;
          b_rdy_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          b_rdy_d = 1'b0;
          if (m_nastilite.b_resp != 2'b00) begin
            fail = 1'b1;
          end else if (idx_q == LAST) begin
`ifdef CFG_LOADER_VERIFY_EN
            nidx     = 4'd0;
            issue_rd = 1'b1;
`else
            finish   = 1'b1;
`endif
          end else begin
            issue_wr = 1'b1;
          end
        end
      end
`ifdef CFG_LOADER_VERIFY_EN
      RD_REQ: begin
        if (ar_hs) begin
          ar_vld_d = 1'b0;
          r_rdy_d  = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          r_rdy_d = 1'b0;
          if ((m_nastilite.r_resp != 2'b00) ||
              (m_nastilite.r_data != word_sel(tbl_q, idx_q))) begin
            fail = 1'b1;
          end else if (idx_q == LAST) begin
            finish = 1'b1;
          end else begin
            issue_rd = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (issue_wr) begin
      state_d   = WR_REQ;
      idx_d     = nidx;
      aw_vld_d  = 1'b1;
      aw_addr_d = word_addr(nidx);
      w_vld_d   = 1'b1;
      w_dat_d   = word_sel(tbl_d, nidx);
      w_strb_d  = '1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

`ifdef CFG_LOADER_VERIFY_EN
    if (issue_rd) begin
      state_d   = RD_REQ;
      idx_d     = nidx;
      ar_vld_d  = 1'b1;
      ar_addr_d = word_addr(nidx);
    end
`endif

    if (fail) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end
    if (finish | fail) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge m_nastilite_clk or negedge m_nastilite_aresetn) begin
    if (!m_nastilite_aresetn) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      tbl_q     <= '0;
      aw_vld_q  <= 1'b0;
      aw_addr_q <= '0;
      w_vld_q   <= 1'b0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_rdy_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
`ifdef CFG_LOADER_VERIFY_EN
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      r_rdy_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tbl_q     <= tbl_d;
      aw_vld_q  <= aw_vld_d;
      aw_addr_q <= aw_addr_d;
      w_vld_q   <= w_vld_d;
      w_dat_q   <= w_dat_d;
      w_strb_q  <= w_strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_rdy_q   <= b_rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
`ifdef CFG_LOADER_VERIFY_EN
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      r_rdy_q   <= r_rdy_d;
`endif
    end
  end

  assign m_nastilite.aw_valid = aw_vld_q;
  assign m_nastilite.aw_addr  = aw_addr_q;
  assign m_nastilite.w_valid  = w_vld_q;
  assign m_nastilite.w_data   = w_dat_q;
  assign m_nastilite.w_strb   = w_strb_q;
  assign m_nastilite.b_ready  = b_rdy_q;

`ifdef CFG_LOADER_VERIFY_EN
  assign m_nastilite.ar_valid = ar_vld_q;
  assign m_nastilite.ar_addr  = ar_addr_q;
  assign m_nastilite.r_ready  = r_rdy_q;
`else
  // Read channel is unused without the readback pass
  logic unused_rd;
  assign unused_rd = ^{m_nastilite.ar_ready, m_nastilite.r_valid,
                       m_nastilite.r_data, m_nastilite.r_resp};
  assign m_nastilite.ar_valid = 1'b0;
  assign m_nastilite.ar_addr  = '0;
  assign m_nastilite.r_ready  = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign err_index = err_idx_q;

endmodule
